// File: rtl/descrambler_ctrl.sv
// descrambler_ctrl: RX frame sequencer between the Viterbi bit stream and the MAC byte port;
// recovers the descrambler seed, checks SERVICE, packs PSDU bytes LSB-first and drops tail/pad.
module descrambler_ctrl #(
  parameter int LEN_W    = 12,
  parameter int SVC_BITS = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [LEN_W-1:0] iLength,
  input  logic             iValid,
  input  logic             iData,
  output logic             oDsSEN,
  output logic             oDsData,
  input  logic             iDsData,
  output logic [6:0]       oSeed,
  output logic [7:0]       oByte,
  output logic             oByteValid,
  output logic             oBusy,
  output logic             oDone,
  output logic             oSvcErr,
  output logic             oUnderrun
);
  typedef enum logic [2:0] {IDLE, SEED, SVC, DATA, DRAIN} state_t;
  localparam logic [LEN_W+2:0] SEED_LAST = (LEN_W+3)'(6);
  localparam logic [LEN_W+2:0] SVC_LAST  = (LEN_W+3)'(SVC_BITS - 8);
  state_t           state_q, state_d;
  logic [LEN_W+2:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q;
  logic [6:0]       seed_q, sh_q;
  logic [7:0]       byte_q;
  logic             bv_q, done_q, svc_q, und_q, und_d, last_bit;
  assign oDsData    = iData;
  assign oDsSEN     = (state_q == SEED) & iValid;
  assign oBusy      = state_q != IDLE;
  assign oSeed      = seed_q;
  assign oByte      = byte_q;
  assign oByteValid = bv_q;
  assign oDone      = done_q;
  assign oSvcErr    = svc_q;
  assign oUnderrun  = und_q;
  assign last_bit   = cnt_q == {len_q, 3'b000} - 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    und_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (iStart) state_d = SEED;
      end
      SEED:
        if (iValid) begin
          cnt_d   = cnt_q == SEED_LAST ? '0 : cnt_q + 1'b1;
          state_d = cnt_q == SEED_LAST ? SVC : SEED;
        end else if (cnt_q != '0) und_d = 1'b1;
      SVC:
        if (iValid) begin
          cnt_d   = cnt_q == SVC_LAST ? '0 : cnt_q + 1'b1;
          state_d = cnt_q == SVC_LAST ? (len_q == '0 ? DRAIN : DATA) : SVC;
        end else und_d = 1'b1;
      DATA:
        if (iValid) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = last_bit ? DRAIN : DATA;
        end else und_d = 1'b1;
      DRAIN: if (!iValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (und_d) state_d = IDLE;
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      len_q  <= '0;
      seed_q <= '0;
      sh_q   <= '0;
      byte_q <= '0;
      bv_q   <= 1'b0;
      done_q <= 1'b0;
      svc_q  <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      bv_q   <= 1'b0;
      done_q <= (state_q == DRAIN) & ~iValid;
      if (state_q == IDLE && iStart) begin
        len_q <= iLength;
        svc_q <= 1'b0;
        und_q <= 1'b0;
      end
      if (oDsSEN) seed_q <= {seed_q[5:0], iData};
      if (state_q == SVC && iValid && iDsData) svc_q <= 1'b1;
      if (und_d) und_q <= 1'b1;
      if (state_q == DATA && iValid) begin
        sh_q <= {iDsData, sh_q[6:1]};
        if (cnt_q[2:0] == 3'd7) begin
          byte_q <= {iDsData, sh_q};
          bv_q   <= 1'b1;
        end
      end
    end
endmodule
